instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch.sv | 133 +++++++++++++
 tb/tb_instruction_fetch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding word fetches and
// fills the IF/ID register feeding the R-type decode controller, with stall and JR flush.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        jr_taken,
    input  logic [31:0] jr_target,
    input  logic        id_stall,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_valid
);

    typedef enum logic [1:0] {S_RESET, S_FETCH, S_DROP, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] pend_instr_q, pend_instr_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        if_valid_q, if_valid_d;
    logic        accept;
    logic [31:0] target;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

    assign accept = !if_valid_q || !id_stall;
    assign target = word_align(jr_target);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        pend_instr_d  = pend_instr_q;
        pend_pc_d     = pend_pc_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        if_valid_d    = if_valid_q;
        if (!id_stall) begin
            if_valid_d = 1'b0;
        end
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ready) begin
                    if (jr_taken) begin
                        pc_d = target;
                    end else if (accept) begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_d       = pc_q + 32'd4;
                    end else begin
                        pend_instr_d = imem_rdata;
                        pend_pc_d    = pc_q;
                        state_d      = S_HOLD;
                    end
                end else if (jr_taken) begin
                    redirect_pc_d = target;
                    state_d       = S_DROP;
                end
            end
            S_DROP: begin
                // The wrong-path request cannot be cancelled, so wait it out and discard it.
                if (imem_ready) begin
                    pc_d    = jr_taken ? target : redirect_pc_q;
                    state_d = S_FETCH;
                end else if (jr_taken) begin
                    redirect_pc_d = target;
                end
            end
            S_HOLD: begin
                if (jr_taken) begin
                    pc_d    = target;
                    state_d = S_FETCH;
                end else if (!id_stall) begin
                    if_instr_d = pend_instr_q;
                    if_pc_d    = pend_pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + 32'd4;
                    state_d    = S_FETCH;
                end
            end
            default: state_d = S_RESET;
        endcase
        if (jr_taken) begin
            if_valid_d = 1'b0;
        end
        req_d = (state_d == S_FETCH) || (state_d == S_DROP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_RESET;
            req_q         <= 1'b0;
            pc_q          <= RESET_PC;
            redirect_pc_q <= 32'h0;
            pend_instr_q  <= 32'h0;
            pend_pc_q     <= 32'h0;
            if_instr_q    <= 32'h0;
            if_pc_q       <= 32'h0;
            if_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            pc_q          <= pc_d;
            redirect_pc_q <= redirect_pc_d;
            pend_instr_q  <= pend_instr_d;
            pend_pc_q     <= pend_pc_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_valid_q    <= if_valid_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign if_valid  = if_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed cycle checks plus a scoreboard of consumed IF/ID words.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        jr_taken;
    logic [31:0] jr_target;
    logic        id_stall;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ready;
    logic [31:0] w_rdata;
    logic        w_jr = 1'b0;
    logic [31:0] w_tgt = 32'h0;
    logic        w_stall = 1'b0;
    logic [31:0] w_if_instr;
    logic [31:0] w_if_pc;
    logic        w_if_valid;

    int          checks = 0;
    int          failures = 0;
    int          mem_waits = 0;
    int          mem_cnt = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .jr_taken(jr_taken), .jr_target(jr_target), .id_stall(id_stall),
        .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ready(w_ready), .imem_rdata(w_rdata),
        .jr_taken(w_jr), .jr_target(w_tgt), .id_stall(w_stall),
        .if_instr(w_if_instr), .if_pc(w_if_pc), .if_valid(w_if_valid)
    );

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hAB00_0000;
    endfunction

    assign w_ready = w_req;
    assign w_rdata = tag(w_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Memory model: answers the current request after mem_waits idle cycles.
    always @(negedge clk) begin
        if (!rst_n || !imem_req) begin
            imem_ready = 1'b0;
            mem_cnt    = 0;
        end else if (mem_cnt >= mem_waits) begin
            imem_ready = 1'b1;
            imem_rdata = tag(imem_addr);
            mem_cnt    = 0;
        end else begin
            imem_ready = 1'b0;
            mem_cnt++;
        end
    end

    // Monitor: every word the decoder takes must be the next expected one.
    always @(negedge clk) begin
        logic [31:0] e;
        #3;
        if (if_valid && !id_stall) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual_pc=%h required=none at %0t", if_pc, $time);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", if_pc, e);
                chk("sb_instr", if_instr, tag(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        id_stall  = 1'b0;
        jr_taken  = 1'b0;
        jr_target = 32'h0;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        repeat (3) @(posedge clk);
        tick();
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h100);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("wrap_rst_addr", w_addr, 32'hFFFF_FFF8);
        rst_n = 1'b1;
        tick(); // C1
        chk("c1_addr", imem_addr, 32'h100);
        chk("c1_req", {31'h0, imem_req}, 32'h1);
        chk("c1_valid", {31'h0, if_valid}, 32'h0);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFF8);
        tick(); // C2
        chk("c2_addr", imem_addr, 32'h104);
        chk("c2_ifpc", if_pc, 32'h100);
        chk("c2_valid", {31'h0, if_valid}, 32'h1);
        chk("wrap_addr1", w_addr, 32'hFFFF_FFFC);
        chk("wrap_ifpc0", w_if_pc, 32'hFFFF_FFF8);
        tick(); // C3
        chk("c3_addr", imem_addr, 32'h108);
        chk("c3_ifpc", if_pc, 32'h104);
        chk("wrap_addr2", w_addr, 32'h0000_0000);
        chk("wrap_ifpc1", w_if_pc, 32'hFFFF_FFFC);
        chk("wrap_instr1", w_if_instr, 32'h54FF_FFFC);
        chk("wrap_valid", {31'h0, w_if_valid}, 32'h1);
        id_stall = 1'b1;
        tick(); // C4
        chk("hold_req", {31'h0, imem_req}, 32'h0);
        chk("hold_ifpc", if_pc, 32'h104);
        chk("hold_valid", {31'h0, if_valid}, 32'h1);
        tick(); // C5
        chk("hold_req2", {31'h0, imem_req}, 32'h0);
        chk("hold_ifpc2", if_pc, 32'h104);
        chk("hold_instr2", if_instr, 32'hAB00_0104);
        chk("hold_addr", imem_addr, 32'h108);
        tick(); // C6
        chk("hold_ifpc3", if_pc, 32'h104);
        id_stall = 1'b0;
        exp_q.push_back(32'h2000);
        exp_q.push_back(32'h2004);
        tick(); // C7
        chk("rel_ifpc", if_pc, 32'h108);
        chk("rel_addr", imem_addr, 32'h10C);
        chk("rel_req", {31'h0, imem_req}, 32'h1);
        jr_taken  = 1'b1;
        jr_target = 32'h2003;
        tick(); // C8
        chk("jr_flush", {31'h0, if_valid}, 32'h0);
        chk("jr_addr", imem_addr, 32'h2000);
        jr_taken = 1'b0;
        tick(); // C9
        chk("jr_ifpc", if_pc, 32'h2000);
        chk("jr_valid", {31'h0, if_valid}, 32'h1);
        chk("jr_addr2", imem_addr, 32'h2004);
        mem_waits = 3;
        exp_q.push_back(32'h400);
        tick(); // C10
        chk("w_ifpc", if_pc, 32'h2004);
        chk("w_addr", imem_addr, 32'h2008);
        tick(); // C11
        chk("w_addr2", imem_addr, 32'h2008);
        chk("w_valid", {31'h0, if_valid}, 32'h0);
        jr_taken  = 1'b1;
        jr_target = 32'h400;
        tick(); // C12
        chk("drop_addr", imem_addr, 32'h2008);
        chk("drop_req", {31'h0, imem_req}, 32'h1);
        jr_taken = 1'b0;
        tick(); // C13
        chk("drop_addr2", imem_addr, 32'h2008);
        tick(); // C14
        chk("drop_next", imem_addr, 32'h400);
        chk("drop_valid", {31'h0, if_valid}, 32'h0);
        repeat (4) tick(); // C18
        chk("drop_ifpc", if_pc, 32'h400);
        chk("drop_addr3", imem_addr, 32'h404);
        tick(); // C19
        jr_taken  = 1'b1;
        jr_target = 32'h600;
        tick(); // C20
        chk("drop2_addr", imem_addr, 32'h404);
        jr_target = 32'h500;
        tick(); // C21
        chk("drop2_addr2", imem_addr, 32'h404);
        jr_taken = 1'b0;
        tick(); // C22
        chk("drop2_next", imem_addr, 32'h500);
        chk("drop2_valid", {31'h0, if_valid}, 32'h0);
        mem_waits = 0;
        tick(); // C23
        tick(); // C24
        chk("pre_ifpc", if_pc, 32'h500);
        chk("pre_addr", imem_addr, 32'h504);
        id_stall = 1'b1;
        tick(); // C25
        chk("hold3_req", {31'h0, imem_req}, 32'h0);
        chk("hold3_ifpc", if_pc, 32'h500);
        rst_n = 1'b0;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        tick(); // C26
        chk("mrst_req", {31'h0, imem_req}, 32'h0);
        chk("mrst_addr", imem_addr, 32'h100);
        chk("mrst_valid", {31'h0, if_valid}, 32'h0);
        chk("mrst_instr", if_instr, 32'h0);
        chk("mrst_pc", if_pc, 32'h0);
        rst_n    = 1'b1;
        id_stall = 1'b0;
        tick(); // C27
        chk("mrst_addr2", imem_addr, 32'h100);
        chk("mrst_req2", {31'h0, imem_req}, 32'h1);
        tick(); // C28
        chk("mrst_ifpc", if_pc, 32'h100);
        tick(); // C29
        chk("mrst_ifpc2", if_pc, 32'h104);
        rst_n = 1'b0;
        tick(); // C30
        chk("end_valid", {31'h0, if_valid}, 32'h0);
        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
